// File: rtl/div_clock_ratio_meter.sv
// Measures the period of a slow input (e.g. a divided clock) in clk cycles and
// reports the period, floor(log2(period)) and whether it is a power of two.
module div_clock_ratio_meter #(
  parameter int CNT_W = 16,
  parameter int LOG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [LOG_W-1:0] log2_n,
  output logic             pow2,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] cnt, cnt_nx, period_nx;
  logic [LOG_W-1:0] log2_nx, msb_idx;
  logic             pow2_nx, valid_nx, timeout_nx;

  // Synchronizer keeps running while disabled so re-enabling sees no stale edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_comb begin
    msb_idx = '0;
    for (int unsigned i = 1; i < CNT_W; i++) begin
      if (cnt[i]) msb_idx = LOG_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      log2_n  <= '0;
      pow2    <= 1'b0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      period  <= period_nx;
      log2_n  <= log2_nx;
      pow2    <= pow2_nx;
      valid   <= valid_nx;
      timeout <= timeout_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    period_nx  = period;
    log2_nx    = log2_n;
    pow2_nx    = pow2;
    valid_nx   = 1'b0;
    timeout_nx = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx   = '0;
          state_nx = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_nx   = CNT_ONE;
            state_nx = MEAS;
          end
        end
        MEAS: begin
          // A rise on the terminal count is still a valid measurement.
          if (rise) begin
            period_nx = cnt;
            log2_nx   = msb_idx;
            pow2_nx   = ((cnt & (cnt - CNT_ONE)) == '0);
            valid_nx  = 1'b1;
            cnt_nx    = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            timeout_nx = 1'b1;
            cnt_nx     = '0;
            state_nx   = ARM;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule
